nbit_demux1x2_buf: RTL and testbench
====================================

# nbit_demux1x2_buf

Buffered N-bit 1-to-2 demultiplexer with valid/ready handshakes: steers each accepted input word to output channel 0 or 1 according to a per-word select bit. Every channel has its own 2-entry FIFO, so a stall on one channel does not block words bound for the other. It sits on the return path of the unified memory port and splits responses between the fetch path (channel 0) and the load path (channel 1).

## Interface
- N, 32, data width in bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  input word present.
- in_data  in  N  input word.
- in_sel  in  1  destination: 0 = channel 0, 1 = channel 1; qualified by in_valid.
- in_ready  out  1  block accepts the word this cycle.
- out0_valid  out  1  channel 0 head entry valid.
- out0_data  out  N  channel 0 head word.
- out0_ready  in  1  channel 0 consumer takes the head.
- out1_valid / out1_data / out1_ready  same as channel 0, for channel 1.
- cnt0, cnt1  out  2  channel occupancy, 0..2.

## Operation
- Input transfer occurs when in_valid && in_ready; the word is pushed into FIFO[in_sel] only.
- in_ready = (cnt[in_sel] != 2); purely a function of in_sel and the registered counts, with no path from out*_ready.
- Output transfer on channel k occurs when outk_valid && outk_ready; the head entry is popped.
- outk_valid = (cntk != 0); outk_data = head entry, driven from registers; its value is don't-care when invalid, but it must hold stable while valid and not popped.
- Per-channel order is preserved. No ordering relation exists between channels.
- Per-channel count update: push only gives +1; pop only gives -1; push and pop together leave the count unchanged, head advances, and the new word goes to the tail.
- Full channel (cnt = 2): in_ready is low for words selected to it, even if a pop happens the same cycle. Words for the other channel are still accepted.
- Empty channel: outk_valid is low and outk_ready is ignored. A push into an empty channel is not visible until the next cycle (no bypass).
- While in_valid is low, in_sel is ignored. The upstream side must hold in_data and in_sel stable while in_valid && !in_ready.
- Reset, including mid-operation: both FIFOs are flushed and all buffered words are discarded.

## Timing
- Reset values: out0_valid = out1_valid = 0; cnt0 = cnt1 = 0; out0_data = out1_data = 0 (storage and pointers cleared); in_ready = 1 the cycle after reset is released.
- While rst = 0: in_ready = 0 and no input or output transfers occur.
- Latency: a word accepted at edge t is presented on outk_valid/outk_data after edge t, so it is poppable at edge t+1.
- Throughput: 1 word/cycle in total. Each channel sustains 1 word/cycle when its consumer holds ready high.
- Pointers: 1-bit read and write pointers per FIFO, wrapping modulo 2.

## Structure
- Sub-module nbit_fifo2 #(N): 2-entry register FIFO with push, pop, full, empty, count[1:0] and head data. It is instantiated twice from a generate loop over channel index.
- The top level holds only the steering logic: push_k = in_valid && in_ready && (in_sel == k), and in_ready muxing.
- Shared package: none. The depth constant (2) and count width (2) stay local to nbit_fifo2.

## Test plan
- Reset then idle: hold rst = 0 for 3 cycles with in_valid = 1 -> cnt0 = cnt1 = 0, both out*_valid = 0, no push; after release, in_ready = 1.
- Steering: send 0xAAAA0001 with sel 0 and 0x55550002 with sel 1 on consecutive cycles, both readies high -> out0 shows 0xAAAA0001 one cycle after acceptance and out1 shows 0x55550002 one cycle after its acceptance; each appears exactly once.
- Backpressure isolation: out0_ready = 0; send 0x10, 0x11, 0x12 to ch0 -> cnt0 = 2 and in_ready drops on the third word (0x12 held). Interleaved 0x20 to ch1 is accepted with cnt1 = 1. Raise out0_ready -> pops 0x10, 0x11, 0x12 in order.
- Full with simultaneous pop: cnt0 = 2, out0_ready = 1, in_valid = 1 with sel 0 -> that cycle in_ready = 0 and cnt0 goes to 1; the word is accepted the next cycle and cnt0 returns to 2.
- Simultaneous push and pop at cnt1 = 1 -> cnt1 stays 1 and data order stays FIFO over 100 random words; a scoreboard matches each channel's output stream to its input stream.
- Reset mid-operation: cnt0 = 2, cnt1 = 1, assert rst for 1 cycle -> all counts 0 and valids 0; previously buffered words never appear.

Source files
------------

// File: rtl/nbit_fifo2.sv
// Two-entry register FIFO with count, full/empty flags and registered head.
// Ports: clk, rst (sync active-low), push/din in, pop in, full/empty/count/dout out.
module nbit_fifo2 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count,
  output logic [N-1:0] dout
);

  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic [N-1:0]  mem [DEPTH];
  logic          rptr;
  logic          wptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  // pop on an empty FIFO is ignored
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rptr <= 1'b0;
      wptr <= 1'b0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (do_pop) begin
        rptr <= ~rptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;
  assign dout  = mem[rptr];

endmodule

// File: rtl/nbit_demux1x2_buf.sv
// Buffered 1-to-2 demux: steers each input word to a per-channel 2-entry FIFO.
// Ports: clk, rst (sync active-low), in_* handshake, out0_*/out1_* handshakes, cnt0/cnt1.
module nbit_demux1x2_buf #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  input  logic         in_sel,
  output logic         in_ready,
  output logic         out0_valid,
  output logic [N-1:0] out0_data,
  input  logic         out0_ready,
  output logic         out1_valid,
  output logic [N-1:0] out1_data,
  input  logic         out1_ready,
  output logic [1:0]   cnt0,
  output logic [1:0]   cnt1
);

  logic [1:0]   push;
  logic [1:0]   pop;
  logic [1:0]   full;
  logic [1:0]   empty;
  logic [1:0]   cnt  [2];
  logic [N-1:0] dout [2];

  // only registered counts feed in_ready; a same-cycle pop never frees a slot
  assign in_ready = rst && !full[in_sel];
  assign pop      = {out1_ready, out0_ready};

  for (genvar k = 0; k < 2; k++) begin : g_ch
    assign push[k] = in_valid && in_ready && (in_sel == 1'(k));

    nbit_fifo2 #(.N(N)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (in_data),
      .full  (full[k]),
      .empty (empty[k]),
      .count (cnt[k]),
      .dout  (dout[k])
    );
  end

  assign out0_valid = !empty[0];
  assign out1_valid = !empty[1];
  assign out0_data  = dout[0];
  assign out1_data  = dout[1];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

endmodule

// File: tb/tb_nbit_demux1x2_buf.sv
// Self-checking bench for nbit_demux1x2_buf: vector table, hand sequences,
// random traffic; per-channel scoreboards track every accepted word.
module tb_nbit_demux1x2_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_ready;
  logic        out0_valid;
  logic [31:0] out0_data;
  logic        out0_ready;
  logic        out1_valid;
  logic [31:0] out1_data;
  logic        out1_ready;
  logic [1:0]  cnt0;
  logic [1:0]  cnt1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  always #5 clk = ~clk;

  nbit_demux1x2_buf #(.N(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endfunction

  // scoreboard: sample handshakes mid-cycle, before the transfer edge
  always @(negedge clk) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) chk("ch0_unexpected", out0_data, 32'hxxxxxxxx);
        else chk("ch0_data", out0_data, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) chk("ch1_unexpected", out1_data, 32'hxxxxxxxx);
        else chk("ch1_data", out1_data, q1.pop_front());
      end
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else q0.push_back(in_data);
      end
    end
  end

  typedef struct {
    logic        v;
    logic        sel;
    logic [31:0] d;
    logic        r0;
    logic        r1;
    logic        rdy;
    logic [1:0]  c0;
    logic [1:0]  c1;
  } vec_t;

  vec_t tbl [12];

  task automatic apply(input vec_t t, input int idx);
    in_valid   = t.v;
    in_sel     = t.sel;
    in_data    = t.d;
    out0_ready = t.r0;
    out1_ready = t.r1;
    @(negedge clk);
    chk($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'(t.rdy));
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_cnt0", idx), 32'(cnt0), 32'(t.c0));
    chk($sformatf("vec%0d_cnt1", idx), 32'(cnt1), 32'(t.c1));
  endtask

  task automatic send(input logic sel, input logic [31:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int cyc;
    logic took;

    //            v  sel data          r0 r1 rdy c0 c1
    tbl[0]  = '{1, 0, 32'h10, 0, 0, 1, 1, 0};
    tbl[1]  = '{1, 0, 32'h11, 0, 0, 1, 2, 0};
    tbl[2]  = '{1, 0, 32'h12, 0, 0, 0, 2, 0};
    tbl[3]  = '{1, 1, 32'h20, 0, 0, 1, 2, 1};
    tbl[4]  = '{1, 0, 32'h12, 1, 0, 0, 1, 1};
    tbl[5]  = '{1, 0, 32'h12, 0, 0, 1, 2, 1};
    tbl[6]  = '{0, 0, 32'h0,  1, 1, 0, 1, 0};
    tbl[7]  = '{0, 1, 32'h0,  1, 1, 1, 0, 0};
    tbl[8]  = '{1, 1, 32'h21, 0, 1, 1, 0, 1};
    tbl[9]  = '{1, 1, 32'h22, 0, 1, 1, 0, 1};
    tbl[10] = '{1, 0, 32'h13, 1, 1, 1, 1, 0};
    tbl[11] = '{0, 0, 32'h0,  1, 1, 1, 0, 0};

    rst        = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 32'hDEADBEEF;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_v0", 32'(out0_valid), 32'd0);
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_d0", out0_data, 32'd0);
    chk("rst_d1", out1_data, 32'd0);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) apply(tbl[i], i);

    // steering with both consumers ready
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(1'b0, 32'hAAAA0001);
    chk("steer_v0", 32'(out0_valid), 32'd1);
    chk("steer_d0", out0_data, 32'hAAAA0001);
    chk("steer_v1_idle", 32'(out1_valid), 32'd0);
    send(1'b1, 32'h55550002);
    chk("steer_v0_once", 32'(out0_valid), 32'd0);
    chk("steer_v1", 32'(out1_valid), 32'd1);
    chk("steer_d1", out1_data, 32'h55550002);
    @(posedge clk);
    #1;
    chk("steer_v1_once", 32'(out1_valid), 32'd0);

    // random traffic; held words stay stable until accepted
    acc = 0;
    cyc = 0;
    in_valid = 1'b0;
    while (acc < 100 && cyc < 3000) begin
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 4) != 0);
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (took) begin
        acc++;
        in_valid = 1'b0;
      end
    end
    if (acc < 100) chk("rand_timeout", 32'(acc), 32'd100);
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
    chk("drain_cnt0", 32'(cnt0), 32'd0);
    chk("drain_cnt1", 32'(cnt1), 32'd0);

    // reset mid-operation discards buffered words
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(1'b0, 32'h30);
    send(1'b0, 32'h31);
    send(1'b1, 32'h40);
    chk("pre_rst_cnt0", 32'(cnt0), 32'd2);
    chk("pre_rst_cnt1", 32'(cnt1), 32'd1);
    rst        = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("mid_rst_cnt0", 32'(cnt0), 32'd0);
    chk("mid_rst_cnt1", 32'(cnt1), 32'd0);
    repeat (3) begin
      chk("mid_rst_v0", 32'(out0_valid), 32'd0);
      chk("mid_rst_v1", 32'(out1_valid), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
